nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle adder for WIDTH = 4·NIBBLES bit operands that reuses a single 4-bit ripple adder, one nibble per cycle, least-significant nibble first. Carry-out is registered and fed back as the next cycle's carry-in. The block sits directly around the 4-bit ripple adder: it feeds the adder its operand nibbles and carry, and consumes the adder's sum and carry-out. Operands arrive and results leave through valid/ready handshakes.

## Interface
- NIBBLES, 4, number of 4-bit slices; WIDTH = 4·NIBBLES; legal range 1..16
- clk  in  1  rising-edge clock, only clock in the block
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair and cin presented
- in_ready  out  1  block can accept; high only in IDLE and not in reset
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry into nibble 0
- out_valid  out  1  result registers hold a completed sum
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH
- cout  out  1  unsigned carry out of bit WIDTH-1
- ovf  out  1  two's-complement overflow

## Operation
- **Reset.**
  - With rst high at a clock edge, the state goes to IDLE.
  - sum=0, cout=0, ovf=0, out_valid=0, nibble index=0, carry register=0.
  - in_ready=0 while rst is high.
  - Reset overrides every other event, including mid-RUN and in DONE; a discarded operation produces no output.
- **IDLE.**
  - in_ready=1.
  - On in_valid&in_ready: latch a, b; set carry register to cin and index to 0; go to RUN.
  - sum, cout and ovf keep their previous values; out_valid=0.
- **RUN.** Once per cycle:
  - The adder receives a[4i+3:4i], b[4i+3:4i] and the carry register.
  - Adder s is written to sum[4i+3:4i]; adder co is written to the carry register.
  - The index increments.
  - When i = NIBBLES-1:
    - cout <= co.
    - ovf <= (a[WIDTH-1] == b[WIDTH-1]) && (s[3] != a[WIDTH-1]).
    - State goes to DONE.
  - in_ready=0 throughout RUN; in_valid is ignored.
- **DONE.**
  - out_valid=1.
  - sum, cout and ovf are stable and unchanged until the handshake.
  - On out_ready: go to IDLE and clear out_valid.
  - out_ready is ignored outside DONE.
- **Arithmetic.**
  - Unsigned modulo 2^WIDTH. cout is the true carry.
  - ovf is valid for signed interpretation of a and b.
  - No saturation.

## Timing
- An accept edge at cycle T starts RUN at T+1.
- Nibble i is written at the edge ending cycle T+1+i.
- out_valid rises at cycle T+NIBBLES+1. Latency is NIBBLES+1 cycles from the accept edge.
- With out_ready held high:
  - out_valid lasts 1 cycle.
  - IDLE follows, and the next accept can occur one cycle later.
  - Minimum initiation interval is NIBBLES+2 cycles.
- The carry path is fully registered between nibbles. The combinational path is one 4-bit ripple plus the write-enable decode.
- Upper sum nibbles show the previous result until they are overwritten during RUN. Consumers sample sum only when out_valid is high.

## Structure
- Shared package `adder_pkg`:
  - NIB_W = 4.
  - State encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Index width function clog2.
- One sub-module instance: the team's 4-bit ripple adder, full_adder_4bit_ripple (ports s, co, a, b, ci).
- All sequencing, nibble muxing and result registers stay in nibble_serial_adder.

## Test plan
- NIBBLES=4:
  - Stimulus: a=0x00FF, b=0x0001, cin=0.
  - Required: sum=0x0100, cout=0, ovf=0. out_valid high exactly 5 cycles after the accept edge. in_ready low from the accept edge until the cycle after the out handshake.
- Unsigned wrap:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0.
  - Required: sum=0x0000, cout=1, ovf=0.
- Signed overflow:
  - Stimulus: a=0x7FFF, b=0x0001.
  - Required: sum=0x8000, cout=0, ovf=1.
  - Then a=0x8000, b=0x8000: sum=0x0000, cout=1, ovf=1.
- Carry in:
  - Stimulus: a=0x1234, b=0x0000, cin=1.
  - Required: sum=0x1235.
- Backpressure:
  - Stimulus: out_ready low for 3 cycles in DONE, with in_valid high and new operands presented.
  - Required: sum, cout and ovf hold; in_ready=0; no new operands accepted. After out_ready rises, the next op is accepted one cycle later and its result is correct.
- Reset mid-RUN:
  - Stimulus: assert rst during nibble 2.
  - Required: next cycle IDLE, out_valid=0, sum=0; no result appears. A subsequent op with NIBBLES=1 (a=0xF, b=0x1) gives sum=0x0, cout=1, with latency 2.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: slice width, FSM states,
// and the index-width helper.
package adder_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Nibble index width, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/full_adder_4bit_ripple.sv
// 4-bit ripple-carry adder: s = a + b + ci, co = carry out of bit 3.
module full_adder_4bit_ripple
    import adder_pkg::*;
(
    output logic [NIB_W-1:0] s,
    output logic             co,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             ci
);

    logic [NIB_W:0] c;

    // Chain of full adders, carry rippling from bit 0 upward.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < NIB_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one shared 4-bit ripple adder.
// Nibbles are processed LSB first; the carry is registered between nibbles.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int WIDTH   = NIB_W * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               IDX_W = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

    state_t                        state;
    logic [NIBBLES-1:0][NIB_W-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0]              idx;
    logic                          carry;
    logic [NIB_W-1:0]              a_nib, b_nib, s_nib;
    logic                          co_nib;

    assign in_ready = (state == IDLE) && !rst;
    assign sum      = sum_q;

    // Route the current operand nibbles to the shared adder.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (idx == IDX_W'(k)) begin
                a_nib = a_q[k];
                b_nib = b_q[k];
            end
        end
    end

    full_adder_4bit_ripple u_add (
        .s  (s_nib),
        .co (co_nib),
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry)
    );

    // Sequencer: accept operands, step one nibble per cycle, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            idx       <= '0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q   <= a;
                        b_q   <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Only the nibble under the index is written; upper nibbles
                    // keep the previous result until their turn.
                    for (int k = 0; k < NIBBLES; k++) begin
                        if (idx == IDX_W'(k)) sum_q[k] <= s_nib;
                    end
                    carry <= co_nib;
                    if (idx == LAST) begin
                        cout      <= co_nib;
                        // Same-sign operands producing a different-sign result.
                        ovf       <= (a_q[NIBBLES-1][NIB_W-1] == b_q[NIBBLES-1][NIB_W-1]) &&
                                     (s_nib[NIB_W-1] != a_q[NIBBLES-1][NIB_W-1]);
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench: directed operand pairs with hand-computed results for a
// 4-nibble and a 1-nibble instance, plus a cycle model of the handshakes.
module tb_nibble_serial_adder;

    localparam int N4 = 4;
    localparam int N1 = 1;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        iv4 = 1'b0, ir4, cin4 = 1'b0, ov4, or4 = 1'b1, co4, of4;
    logic [15:0] a4 = '0, b4 = '0, s4;
    logic        iv1 = 1'b0, ir1, cin1 = 1'b0, ov1, or1 = 1'b1, co1, of1;
    logic [3:0]  a1 = '0, b1 = '0, s1;

    exp_t q4[$];
    exp_t q1[$];
    exp_t e4, e1;
    int   tests = 0;
    int   fails = 0;
    int   p4 = 0;
    int   p1 = 0;
    bit   chk_on = 1'b0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(cin4),
        .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(of4)
    );

    nibble_serial_adder #(.NIBBLES(N1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Phase model: 0 idle, 1..N running, N+1 holding result.
    always @(posedge clk) begin
        if (rst) p4 <= 0;
        else if (p4 == 0) begin if (iv4) p4 <= 1; end
        else if (p4 == N4 + 1) begin if (or4) p4 <= 0; end
        else p4 <= p4 + 1;
    end

    always @(posedge clk) begin
        if (rst) p1 <= 0;
        else if (p1 == 0) begin if (iv1) p1 <= 1; end
        else if (p1 == N1 + 1) begin if (or1) p1 <= 0; end
        else p1 <= p1 + 1;
    end

    // Monitor: handshake timing every cycle, result data at each output handshake.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("in_ready4", ir4, !rst && p4 == 0);
            chk("out_valid4", ov4, p4 == N4 + 1);
            if (ov4 && or4) begin
                if (q4.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected4: result %h with nothing pending", s4);
                end else begin
                    e4 = q4.pop_front();
                    chk("sum4", s4, e4.s);
                    chk("cout4", co4, e4.c);
                    chk("ovf4", of4, e4.o);
                end
            end
            chk("in_ready1", ir1, !rst && p1 == 0);
            chk("out_valid1", ov1, p1 == N1 + 1);
            if (ov1 && or1) begin
                if (q1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected1: result %h with nothing pending", s1);
                end else begin
                    e1 = q1.pop_front();
                    chk("sum1", s1, e1.s);
                    chk("cout1", co1, e1.c);
                    chk("ovf1", of1, e1.o);
                end
            end
        end
    end

    task automatic send(input int w, input logic [15:0] a, input logic [15:0] b, input logic ci,
                        input logic [15:0] es, input logic ec, input logic eo, input bit push);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        if (w == 0) begin a4 = a; b4 = b; cin4 = ci; iv4 = 1'b1; end
        else begin a1 = a[3:0]; b1 = b[3:0]; cin1 = ci; iv1 = 1'b1; end
        while (((w == 0) ? ir4 : ir1) !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $display("FAIL accept_timeout: in_ready never rose for op %h+%h", a, b);
        end else if (push) begin
            e.s = es; e.c = ec; e.o = eo;
            if (w == 0) q4.push_back(e); else q1.push_back(e);
        end
        @(posedge clk);
        #1;
        iv4 = 1'b0;
        iv1 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("FAIL drain_timeout: %0d/%0d results still pending", q4.size(), q1.size());
        end
    endtask

    initial begin
        int n;
        // Reset state, sampled while rst is still high.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sum", s4, 16'h0000);
        chk("rst_cout", co4, 1'b0);
        chk("rst_ovf", of4, 1'b0);
        chk("rst_out_valid", ov4, 1'b0);
        chk("rst_in_ready", ir4, 1'b0);
        rst    = 1'b0;
        chk_on = 1'b1;

        send(0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
        send(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
        send(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        send(0, 16'h1234, 16'h0000, 1'b1, 16'h1235, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: hold the result while new operands wait at the input.
        @(posedge clk);
        #1 or4 = 1'b0;
        send(0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (ov4 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bp_out_valid", ov4, 1'b1);
        a4 = 16'h4000; b4 = 16'h4000; cin4 = 1'b0; iv4 = 1'b1;
        repeat (3) begin
            chk("bp_hold_sum", s4, 16'h3333);
            chk("bp_hold_cout", co4, 1'b0);
            chk("bp_hold_ovf", of4, 1'b0);
            chk("bp_in_ready", ir4, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 or4 = 1'b1;
        send(0, 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);

        // Reset during nibble 2 of an operation that must never complete.
        send(0, 16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", ov4, 1'b0);
        chk("mid_rst_sum", s4, 16'h0000);
        chk("mid_rst_cout", co4, 1'b0);
        chk("mid_rst_in_ready", ir4, 1'b0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Single-nibble instance: F + 1 wraps with carry out, latency 2.
        send(1, 16'h000F, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        send(1, 16'h0007, 16'h0001, 1'b0, 16'h0008, 1'b0, 1'b1, 1'b1);
        drain();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
